// File: rtl/spi_reg_pkg.sv
// Shared types and field positions for the SPI register-bus bridge.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_BUS,
    RD_BUS,
    RD_SEND
  } state_t;

  // Register address whose read returns STATUS and then clears it.
  localparam int unsigned STATUS_CLR_ADDR = 0;

  // Read/write flag position within the command word.
  function automatic int unsigned rw_bit(input int unsigned nbit);
    return nbit - 1;
  endfunction

  // STATUS word: sticky error flag in the MSB, overflow flag just below it.
  function automatic int unsigned status_err_bit(input int unsigned nbit);
    return nbit - 1;
  endfunction

  function automatic int unsigned status_ovf_bit(input int unsigned nbit);
    return nbit - 2;
  endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Register-bus handshake between the SPI bridge (master) and the register file (slave).
interface spi_reg_ctrl_if #(
  parameter int unsigned NBIT = 8
) ();

  logic            bus_req;
  logic            bus_we;
  logic [NBIT-2:0] bus_addr;
  logic [NBIT-1:0] bus_wdata;
  logic [NBIT-1:0] bus_rdata;
  logic            bus_ack;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ack
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata,
    output bus_ack
  );

endinterface

// File: rtl/spi_reg_timer.sv
// Per-state watchdog: counts enabled cycles from the last clear, flags the last allowed cycle.
module spi_reg_timer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned   CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Cycle counter; saturates at the expiry value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/spi_reg_ctrl.sv
// Decodes two-word SPI frames into register-bus reads and writes; reports STATUS on tx_data.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int unsigned NBIT    = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [NBIT-1:0] tx_data,
  input  logic [NBIT-1:0] rx_data,
  input  logic            tx_strobe,
  input  logic            rx_strobe,
  spi_reg_ctrl_if.master  bus,
  output logic            err,
  output logic            busy
);

  localparam int unsigned RW_BIT  = rw_bit(NBIT);
  localparam int unsigned ERR_BIT = status_err_bit(NBIT);
  localparam int unsigned OVF_BIT = status_ovf_bit(NBIT);

  state_t          state;
  state_t          state_next;

  logic            req_next;
  logic            we_next;
  logic [NBIT-2:0] addr_next;
  logic [NBIT-1:0] wdata_next;
  logic [NBIT-1:0] tx_next;

  logic            sticky_err;
  logic            sticky_next;
  logic            ovf;
  logic            ovf_next;
  logic            late;
  logic            late_next;
  logic            late_now;

  logic            err_c;
  logic            set_ovf;
  logic            clr_status;
  logic            load_rd;
  logic            clr_addr;

  logic [NBIT-1:0] status_cur;
  logic [NBIT-1:0] status_next;

  logic            expired;
  logic            tmr_clr;
  logic            tmr_en;

  // Counter restarts on every state change and only runs outside IDLE.
  assign tmr_clr  = (state_next != state);
  assign tmr_en   = (state != IDLE);
  assign clr_addr = (bus.bus_addr == (NBIT-1)'(STATUS_CLR_ADDR));
  assign busy     = (state != IDLE);
  assign err      = err_c;

  spi_reg_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (expired)
  );

  // Current STATUS word assembled from the sticky flags.
  always_comb begin
    status_cur          = '0;
    status_cur[ERR_BIT] = sticky_err;
    status_cur[OVF_BIT] = ovf;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, error detection and next values for all registered outputs.
  always_comb begin
    state_next  = state;
    req_next    = bus.bus_req;
    we_next     = bus.bus_we;
    addr_next   = bus.bus_addr;
    wdata_next  = bus.bus_wdata;
    late_next   = late;
    late_now    = late | tx_strobe | rx_strobe;
    err_c       = 1'b0;
    set_ovf     = 1'b0;
    clr_status  = 1'b0;
    load_rd     = 1'b0;

    case (state)
      IDLE: begin
        if (rx_strobe) begin
          addr_next = rx_data[NBIT-2:0];
          late_next = 1'b0;
          if (rx_data[RW_BIT]) begin
            state_next = RD_BUS;
            req_next   = 1'b1;
            we_next    = 1'b0;
          end else begin
            state_next = WR_DATA;
          end
        end
      end

      WR_DATA: begin
        if (rx_strobe) begin
          wdata_next = rx_data;
          req_next   = 1'b1;
          we_next    = 1'b1;
          state_next = WR_BUS;
        end else if (expired) begin
          err_c      = 1'b1;
          state_next = IDLE;
        end
      end

      WR_BUS: begin
        if (rx_strobe) begin
          err_c = 1'b1;
        end
        if (bus.bus_ack) begin
          req_next   = 1'b0;
          state_next = IDLE;
        end else if (expired) begin
          err_c      = 1'b1;
          req_next   = 1'b0;
          state_next = IDLE;
        end
      end

      RD_BUS: begin
        // A strobe here means the master has already started the data word;
        // the read still completes on the bus but its data is dropped.
        if (tx_strobe || rx_strobe) begin
          err_c   = 1'b1;
          set_ovf = 1'b1;
        end
        if (bus.bus_ack) begin
          req_next = 1'b0;
          if (late_now) begin
            state_next = IDLE;
          end else begin
            state_next = RD_SEND;
            load_rd    = 1'b1;
            clr_status = clr_addr;
          end
        end else if (expired) begin
          err_c      = 1'b1;
          req_next   = 1'b0;
          state_next = IDLE;
        end else begin
          late_next = late_now;
        end
      end

      RD_SEND: begin
        if (rx_strobe) begin
          state_next = IDLE;
        end else if (expired) begin
          err_c      = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase

    // Error set takes priority over the read-to-clear.
    sticky_next          = (sticky_err & ~clr_status) | err_c;
    ovf_next             = (ovf & ~clr_status) | set_ovf;
    status_next          = '0;
    status_next[ERR_BIT] = sticky_next;
    status_next[OVF_BIT] = ovf_next;

    // Reading the clear address returns the pre-clear STATUS instead of bus data.
    if (state_next == RD_SEND) begin
      if (load_rd) begin
        tx_next = clr_addr ? status_cur : bus.bus_rdata;
      end else begin
        tx_next = tx_data;
      end
    end else begin
      tx_next = status_next;
    end
  end

  // Registered bus outputs, tx word and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      tx_data       <= '0;
      sticky_err    <= 1'b0;
      ovf           <= 1'b0;
      late          <= 1'b0;
    end else begin
      bus.bus_req   <= req_next;
      bus.bus_we    <= we_next;
      bus.bus_addr  <= addr_next;
      bus.bus_wdata <= wdata_next;
      tx_data       <= tx_next;
      sticky_err    <= sticky_next;
      ovf           <= ovf_next;
      late          <= late_next;
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed frames plus randomized traffic against a register-file model.
module tb_spi_reg_ctrl;

  localparam int unsigned NBIT    = 8;
  localparam int unsigned TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       tx_strobe;
  logic       rx_strobe;
  logic       err;
  logic       busy;

  spi_reg_ctrl_if #(.NBIT(NBIT)) bus_if ();

  spi_reg_ctrl #(
    .NBIT    (NBIT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .tx_strobe (tx_strobe),
    .rx_strobe (rx_strobe),
    .bus       (bus_if),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned checks    = 0;
  int unsigned failures  = 0;
  int unsigned err_count = 0;

  // Reference model: register file contents and the two STATUS flags.
  logic [7:0] mem [128];
  logic       sticky = 1'b0;
  logic       ovf_m  = 1'b0;

  function automatic logic [7:0] exp_status();
    return {sticky, ovf_m, 6'b0};
  endfunction

  always @(negedge clk) begin
    if (err === 1'b1) err_count++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rx(input logic [7:0] w);
    rx_data   = w;
    rx_strobe = 1'b1;
    tick();
    rx_strobe = 1'b0;
    rx_data   = 8'($urandom);
  endtask

  task automatic pulse_tx();
    tx_strobe = 1'b1;
    tick();
    tx_strobe = 1'b0;
  endtask

  task automatic pulse_ack(input logic [7:0] r);
    bus_if.bus_rdata = r;
    bus_if.bus_ack   = 1'b1;
    tick();
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 8'($urandom);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d, input int unsigned dly);
    int unsigned e0;
    e0 = err_count;
    pulse_rx({1'b0, a});
    check_eq("wr_cmd_busy", busy, 1);
    check_eq("wr_cmd_noreq", bus_if.bus_req, 0);
    pulse_tx();
    repeat ($urandom_range(0, 3)) tick();
    pulse_rx(d);
    check_eq("wr_req", bus_if.bus_req, 1);
    check_eq("wr_we", bus_if.bus_we, 1);
    check_eq("wr_addr", bus_if.bus_addr, a);
    check_eq("wr_wdata", bus_if.bus_wdata, d);
    repeat (dly) tick();
    check_eq("wr_hold_req", bus_if.bus_req, 1);
    check_eq("wr_hold_addr", bus_if.bus_addr, a);
    check_eq("wr_hold_wdata", bus_if.bus_wdata, d);
    pulse_ack(8'($urandom));
    mem[a] = d;
    check_eq("wr_done_req", bus_if.bus_req, 0);
    check_eq("wr_done_busy", busy, 0);
    check_eq("wr_done_tx", tx_data, exp_status());
    check_eq("wr_no_err", err_count - e0, 0);
  endtask

  task automatic do_read(input logic [6:0] a, input int unsigned dly);
    int unsigned e0;
    logic [7:0]  exp;
    e0 = err_count;
    pulse_rx({1'b1, a});
    check_eq("rd_req", bus_if.bus_req, 1);
    check_eq("rd_we", bus_if.bus_we, 0);
    check_eq("rd_addr", bus_if.bus_addr, a);
    check_eq("rd_busy", busy, 1);
    repeat (dly) tick();
    exp = (a == 7'd0) ? exp_status() : mem[a];
    pulse_ack(mem[a]);
    if (a == 7'd0) begin
      sticky = 1'b0;
      ovf_m  = 1'b0;
    end
    check_eq("rd_done_req", bus_if.bus_req, 0);
    check_eq("rd_tx", tx_data, exp);
    check_eq("rd_send_busy", busy, 1);
    pulse_tx();
    repeat ($urandom_range(0, 3)) tick();
    check_eq("rd_tx_hold", tx_data, exp);
    pulse_rx(8'($urandom));
    check_eq("rd_end_tx", tx_data, exp_status());
    check_eq("rd_end_busy", busy, 0);
    check_eq("rd_no_err", err_count - e0, 0);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_req", bus_if.bus_req, 0);
    check_eq("rst_we", bus_if.bus_we, 0);
    check_eq("rst_addr", bus_if.bus_addr, 0);
    check_eq("rst_wdata", bus_if.bus_wdata, 0);
    check_eq("rst_tx", tx_data, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_busy", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e0;
    logic [6:0]  a;
    logic [7:0]  d;
    int unsigned dly;

    rst_n            = 1'b0;
    tx_strobe        = 1'b0;
    rx_strobe        = 1'b0;
    rx_data          = 8'h00;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 8'h00;
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);

    repeat (3) tick();
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (2) tick();
    check_eq("idle_tx_status", tx_data, 0);

    // Basic write and read frames.
    do_write(7'h12, 8'h5A, 3);
    check_eq("wr_mem_model", mem[7'h12], 8'h5A);
    mem[7'h05] = 8'hC3;
    do_read(7'h05, 2);
    tick();

    // Late read data: strobe during RD_BUS sets both flags, read data dropped.
    e0 = err_count;
    a  = 7'h21;
    pulse_rx({1'b1, a});
    repeat (2) tick();
    pulse_tx();
    sticky = 1'b1;
    ovf_m  = 1'b1;
    check_eq("late_req_held", bus_if.bus_req, 1);
    tick();
    pulse_ack(mem[a]);
    check_eq("late_req_drop", bus_if.bus_req, 0);
    check_eq("late_busy", busy, 0);
    check_eq("late_status", tx_data, 8'hC0);
    check_eq("late_err_pulses", err_count - e0, 1);
    tick();

    // Read of address 0 returns pre-clear STATUS, then clears it.
    do_read(7'h00, 1);
    check_eq("clr_status_zero", tx_data, 8'h00);

    // Missing data word times out in WR_DATA.
    e0 = err_count;
    pulse_rx(8'h12);
    repeat (TIMEOUT - 2) tick();
    check_eq("to_no_early_err", err_count - e0, 0);
    check_eq("to_err_low", err, 0);
    tick();
    check_eq("to_err_high", err, 1);
    tick();
    sticky = 1'b1;
    check_eq("to_busy", busy, 0);
    check_eq("to_err_pulses", err_count - e0, 1);
    check_eq("to_status", tx_data, 8'h80);
    do_read(7'h00, 0);

    // Missing bus ack times out in RD_BUS; a later stray ack is ignored.
    e0 = err_count;
    a  = 7'h44;
    pulse_rx({1'b1, a});
    repeat (TIMEOUT - 1) tick();
    check_eq("ackto_err_high", err, 1);
    check_eq("ackto_req_before", bus_if.bus_req, 1);
    tick();
    sticky = 1'b1;
    check_eq("ackto_req_drop", bus_if.bus_req, 0);
    check_eq("ackto_busy", busy, 0);
    pulse_ack(8'hFF);
    check_eq("stray_ack_busy", busy, 0);
    check_eq("stray_ack_req", bus_if.bus_req, 0);
    check_eq("stray_ack_tx", tx_data, exp_status());
    check_eq("ackto_err_pulses", err_count - e0, 1);
    do_read(7'h00, 0);

    // Word arriving during WR_BUS is an error and is ignored.
    e0 = err_count;
    a  = 7'h3C;
    d  = 8'($urandom);
    pulse_rx({1'b0, a});
    pulse_rx(d);
    tick();
    pulse_rx(~d);
    sticky = 1'b1;
    check_eq("wrbus_err_pulses", err_count - e0, 1);
    check_eq("wrbus_req_held", bus_if.bus_req, 1);
    check_eq("wrbus_wdata_kept", bus_if.bus_wdata, d);
    pulse_ack(8'h00);
    mem[a] = d;
    check_eq("wrbus_done_busy", busy, 0);
    check_eq("wrbus_status", tx_data, exp_status());
    do_read(a, 1);
    do_read(7'h00, 0);

    // Data word landing exactly on the timeout cycle wins.
    e0 = err_count;
    a  = 7'h19;
    d  = 8'($urandom);
    pulse_rx({1'b0, a});
    repeat (TIMEOUT - 1) tick();
    pulse_rx(d);
    check_eq("edge_rx_req", bus_if.bus_req, 1);
    check_eq("edge_rx_wdata", bus_if.bus_wdata, d);
    pulse_ack(8'h00);
    mem[a] = d;
    check_eq("edge_rx_no_err", err_count - e0, 0);
    // Bus ack landing exactly on the timeout cycle wins.
    do_read(a, TIMEOUT - 1);
    do_write(7'h2B, 8'($urandom), TIMEOUT - 1);

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      a = 7'($urandom);
      if ($urandom_range(0, 7) == 0) a = 7'd0;
      dly = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : $urandom_range(0, 6);
      if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom), dly);
      else                           do_read(a, dly);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Asynchronous reset in the middle of a bus write.
    pulse_rx({1'b0, 7'h33});
    pulse_rx(8'hA5);
    check_eq("mid_req_before", bus_if.bus_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    sticky = 1'b0;
    ovf_m  = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_req", bus_if.bus_req, 0);
    do_read(7'h33, 2);
    do_write(7'h33, 8'h6E, 1);
    do_read(7'h33, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 Parameter NBIT, default 8, SPI word width; the address field is NBIT-1 bits wide.
REQ-002 Parameter TIMEOUT, default 1024, clk cycles allowed between words of one frame and for a bus ack.
REQ-003 clk  in  1  system clock; reset rst_n, asynchronous, active-low.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 tx_data  out  NBIT  word for the next SPI transfer; the slave samples it while deselected.
REQ-006 rx_data  in  NBIT  received word, valid while rx_strobe is high.
REQ-007 tx_strobe  in  1  one-cycle pulse at the start of an SPI word.
REQ-008 rx_strobe  in  1  one-cycle pulse at the end of an SPI word.
REQ-009 bus_req  out  1  register-bus request; held high until bus_ack.
REQ-010 bus_we  out  1  1 = write, 0 = read; stable while bus_req is high.
REQ-011 bus_addr  out  NBIT-1  register address; stable while bus_req is high.
REQ-012 bus_wdata  out  NBIT  write data; stable while bus_req is high.
REQ-013 bus_rdata  in  NBIT  read data, valid in the cycle bus_ack is high.
REQ-014 bus_ack  in  1  one-cycle completion pulse.
REQ-015 err  out  1  one-cycle pulse on any protocol error.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 Frame format: each SPI word is one ss_n assertion.
- Word 0 is the command: rx_data[NBIT-1] = rw (1 = read), rx_data[NBIT-2:0] = addr.
- Write frame: word 1 carries the write data.
- Read frame: word 1 is a dummy word from the master; the slave shifts out the read data during it.
REQ-018 States are IDLE, WR_DATA, WR_BUS, RD_BUS, RD_SEND.
REQ-019 IDLE: on rx_strobe, latch addr; go to RD_BUS if rw = 1, otherwise to WR_DATA.
REQ-020 WR_DATA: on rx_strobe, latch bus_wdata = rx_data, assert bus_req with bus_we = 1 in the next cycle, and go to WR_BUS.
REQ-021 WR_BUS: on bus_ack, deassert bus_req in the same cycle's next edge and go to IDLE.
REQ-022 RD_BUS: assert bus_req with bus_we = 0; on bus_ack, register bus_rdata into tx_data and go to RD_SEND.
REQ-023 RD_SEND: hold tx_data; on rx_strobe, restore tx_data to STATUS and go to IDLE.
REQ-024 Outside RD_SEND, tx_data = STATUS = {sticky_err, ovf, (NBIT-2) zeros}.
- sticky_err is set by any err pulse and cleared by a read of address 0.
- ovf is set by a tx_strobe in RD_BUS and cleared with sticky_err.
REQ-025 tx_strobe or rx_strobe in RD_BUS (read data late) is an error.
- Pulse err and set ovf.
- Complete the bus read anyway, discard bus_rdata, and go to IDLE.
REQ-026 rx_strobe in WR_BUS is an error: pulse err, ignore the word, and stay until bus_ack.
REQ-027 A timeout counter resets on every state entry and counts clk cycles in WR_DATA, WR_BUS, RD_BUS and RD_SEND.
- Reaching TIMEOUT-1 pulses err and forces IDLE.
- bus_req drops in the same transition; a later stray bus_ack is ignored.
REQ-028 If rx_strobe or bus_ack coincides with the timeout cycle, the event wins and the timeout is not flagged.
REQ-029 bus_req, bus_we, bus_addr and bus_wdata are registered outputs; bus_req rises exactly one cycle after the triggering rx_strobe.
REQ-030 tx_data is registered; read data appears on tx_data one cycle after bus_ack.

Reset
REQ-031 rst_n low asynchronously forces the following, including mid-frame; no bus transaction is resumed:
- state = IDLE, bus_req = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0;
- tx_data = 0, err = 0, busy = 0;
- sticky_err = 0, ovf = 0, counter = 0.

Structure
REQ-032 Package spi_reg_pkg SHALL hold the state enum, the RW bit index, the STATUS bit positions and the STATUS-clear address (0).
REQ-033 The timeout counter SHALL be one sub-module, spi_reg_timer, with inputs clr and en and output expired.
REQ-034 spi_slave SHALL NOT be instantiated inside this module; the parent connects them.

Verification
REQ-035 Write frame: rx_data 0x12, then rx_data 0x5A, bus_ack 3 cycles after bus_req -> bus_we = 1, bus_addr = 0x12, bus_wdata = 0x5A, return to IDLE, err never high.
REQ-036 Read frame: rx_data 0x85, bus_ack with bus_rdata 0xC3 -> bus_addr = 0x05, tx_data = 0xC3 from one cycle after bus_ack until the next rx_strobe, then 0x00.
REQ-037 Late read: ack withheld, then tx_strobe while in RD_BUS -> one err pulse, STATUS = 0xC0 after ack, state IDLE.
REQ-038 Timeout: command 0x12 and no further word for TIMEOUT cycles -> err pulse at cycle TIMEOUT-1, busy = 0 next cycle, STATUS = 0x80.
REQ-039 Clear: a read of address 0 (command 0x80) after an error -> tx_data returns the pre-clear STATUS in RD_SEND and 0x00 afterwards.
REQ-040 Reset mid-frame: rst_n low during WR_BUS -> bus_req = 0 immediately, all outputs at reset values, and the next command decodes normally.
